pc_sequencer: RTL



---
 rtl/pc_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction at a time from
// instruction memory, presents it to the datapath, and advances the PC
// (sequential, branch or jump) when the datapath accepts it. A fetch that
// waits too long for memory parks the block in a sticky error state.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic [15:0] imm,
  input  logic [25:0] instr_index,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic [31:0] retired
);

  // Wait counter only ever needs to hold values up to FETCH_TIMEOUT-1.
  localparam int unsigned WW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(FETCH_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_FETCH,
    S_ISSUE,
    S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   retired_q, retired_d;
  logic          fetch_err_q, fetch_err_d;
  logic [WW-1:0] wait_q, wait_d;

  logic [31:0]   pc_plus4;
  logic [31:0]   branch_tgt;
  logic [31:0]   jump_tgt;

  // Next-PC candidates, all modulo 2^32.
  always_comb begin
    pc_plus4   = pc_q + 32'd4;
    branch_tgt = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    jump_tgt   = {pc_plus4[31:28], instr_index, 2'b00};
  end

  // Next-state and datapath update logic; every register holds by default.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    retired_d   = retired_q;
    fetch_err_d = fetch_err_q;
    wait_d      = wait_q;
    case (state_q)
      S_FETCH: begin
        // A ready on the final allowed cycle still counts as a good fetch.
        if (imem_ready) begin
          instr_d = imem_rdata;
          wait_d  = '0;
          state_d = S_ISSUE;
        end else if (wait_q == WAIT_LAST) begin
          fetch_err_d = 1'b1;
          state_d     = S_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          retired_d = retired_q + 32'd1;
          if (jump)       pc_d = jump_tgt;
          else if (pcsrc) pc_d = branch_tgt;
          else            pc_d = pc_plus4;
          state_d = S_FETCH;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      retired_q   <= '0;
      fetch_err_q <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      retired_q   <= retired_d;
      fetch_err_q <= fetch_err_d;
      wait_q      <= wait_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign retired     = retired_q;
  assign fetch_err   = fetch_err_q;
  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_ISSUE);

endmodule
